load_store_unit: RTL and testbench

Memory-side access sequencer between the pipeline's load/store issue port and the word-wide `data_memory`. It accepts one load or store request at a time over a valid/ready handshake and drives `data_memory`'s write/address/write_data port. Byte and halfword accesses are handled by lane extraction on loads and by read-modify-write on stores. Each request returns exactly one response over a second valid/ready handshake, with misaligned accesses flagged as errors.

---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 78 +++++++
 tb/tb_load_store_unit.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshakes plus the data_memory port
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_write, mem_address, mem_write_data
  );
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer with lane extract and byte/half read-modify-write
module load_store_unit (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;
  state_t state, state_n;
  logic [1:0] size_q, lane_q;
  logic uns_q;
  logic [31:0] wdata_q, shifted, ext, mask, merged;
  logic [4:0] sh;
  logic accept, misaligned;
  assign accept = state == IDLE && bus.req_valid;
  assign misaligned = (bus.req_size == 2'b01 && bus.req_addr[0]) || (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign sh = {lane_q, 3'b000};
  assign shifted = bus.mem_read_data >> sh;
  assign ext = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
               size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
  assign mask = size_q == 2'b00 ? 32'hFF << sh : 32'hFFFF << sh;
  assign merged = (bus.mem_read_data & ~mask) | ((wdata_q << sh) & mask);
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next state and handshake/strobe outputs
  always_comb begin
    state_n = state;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_write = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_n = misaligned ? RESP : !bus.req_write ? LOAD : bus.req_size[1] ? WRITE : RMW_READ;
      end
      LOAD: state_n = RESP;
      RMW_READ: state_n = WRITE;
      WRITE: begin
        bus.mem_write = !reset;
        state_n = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // request capture, memory port registers and response data
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q <= '0;
      lane_q <= '0;
      uns_q <= 1'b0;
      wdata_q <= '0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_write_data <= '0;
    end else begin
      if (accept) begin
        size_q <= bus.req_size;
        lane_q <= bus.req_addr[1:0];
        uns_q <= bus.req_unsigned;
        wdata_q <= bus.req_wdata;
        bus.resp_rdata <= '0;
        bus.resp_error <= misaligned;
        if (!misaligned) begin
          bus.mem_address <= {bus.req_addr[31:2], 2'b00};
          if (bus.req_write && bus.req_size[1]) bus.mem_write_data <= bus.req_wdata;
        end
      end
      if (state == LOAD) bus.resp_rdata <= ext;
      if (state == RMW_READ) bus.mem_write_data <= merged;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
  logic clk, reset;
  logic pre_we;
  logic [3:0] pre_idx;
  logic [31:0] pre_data;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int assertions = 0;
  int failures = 0;
  load_store_unit_if bus();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bus.mem_read_data = mem[bus.mem_address[5:2]];
  // word-wide data_memory: backdoor preload port, otherwise written by the DUT strobe
  always @(posedge clk)
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.mem_write) mem[bus.mem_address[5:2]] <= bus.mem_write_data;

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    return (nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int nb = nbytes(sz);
    longint m = longint'(1) << (8 * nb);
    longint v = longint'(ref_mem[a[5:2]] >> (8 * int'(a[1:0])));
    v = v % m;
    if (!uns && nb < 4 && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int nb = nbytes(sz);
    logic [31:0] w = ref_mem[a[5:2]];
    for (int i = 0; i < nb; i++) w[8 * (int'(a[1:0]) + i) +: 8] = wd[8 * i +: 8];
    ref_mem[a[5:2]] = w;
  endfunction

  task automatic xact(input logic w, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int lat, output int wcnt, output int wcyc);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    lat = -1;
    wcnt = 0;
    wcyc = -1;
    rd = 'x;
    err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (bus.mem_write) begin
        wcnt++;
        wcyc = k;
      end
      if (bus.resp_valid) begin
        lat = k;
        rd = bus.resp_rdata;
        err = bus.resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] v [7];
    logic [31:0] e [7];
    v = '{32'(bus.req_ready), 32'(bus.resp_valid), 32'(bus.resp_error), bus.resp_rdata,
          32'(bus.mem_write), bus.mem_address, bus.mem_write_data};
    e = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 7; i++) begin
      assertions++;
      if (v[i] !== e[i]) begin
        failures++;
        $display("FAIL reset_output[%0d] got %h want %h", i, v[i], e[i]);
      end
    end
  endtask

  task automatic test_word;
    logic [31:0] rd;
    logic err;
    int lat, wcnt, wcyc;
    xact(1'b1, 2'd2, 1'b0, 32'd0, 32'hDEADBEEF, rd, err, lat, wcnt, wcyc);
    ref_store(2'd2, 32'd0, 32'hDEADBEEF);
    assertions++;
    if (lat !== 2 || wcnt !== 1 || wcyc !== 1) begin
      failures++;
      $display("FAIL sw_timing got lat=%0d wcnt=%0d wcyc=%0d want 2 1 1", lat, wcnt, wcyc);
    end
    assertions++;
    if (rd !== 32'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL sw_resp got rd=%h err=%b want 0 0", rd, err);
    end
    xact(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, rd, err, lat, wcnt, wcyc);
    assertions++;
    if (rd !== 32'hDEADBEEF || lat !== 2 || wcnt !== 0) begin
      failures++;
      $display("FAIL lw_data got rd=%h lat=%0d wcnt=%0d want deadbeef 2 0", rd, lat, wcnt);
    end
  endtask

  task automatic test_byte_rmw;
    logic [31:0] rd;
    logic err;
    int lat, wcnt, wcyc;
    xact(1'b1, 2'd2, 1'b0, 32'd4, 32'h11223344, rd, err, lat, wcnt, wcyc);
    ref_store(2'd2, 32'd4, 32'h11223344);
    xact(1'b1, 2'd0, 1'b0, 32'd6, 32'h555555AA, rd, err, lat, wcnt, wcyc);
    ref_store(2'd0, 32'd6, 32'h555555AA);
    assertions++;
    if (mem[1] !== 32'h11AA3344) begin
      failures++;
      $display("FAIL sb_merge got %h want 11aa3344", mem[1]);
    end
    assertions++;
    if (lat !== 3 || wcnt !== 1 || wcyc !== 2 || rd !== 32'd0) begin
      failures++;
      $display("FAIL sb_timing got lat=%0d wcnt=%0d wcyc=%0d rd=%h want 3 1 2 0", lat, wcnt, wcyc, rd);
    end
  endtask

  task automatic test_extension;
    logic [31:0] rd;
    logic err;
    int lat, wcnt, wcyc;
    logic [1:0] sz [4];
    logic un [4];
    logic [31:0] ad [4];
    logic [31:0] ex [4];
    sz = '{2'd1, 2'd1, 2'd0, 2'd0};
    un = '{1'b0, 1'b1, 1'b0, 1'b1};
    ad = '{32'd8, 32'd8, 32'd10, 32'd10};
    ex = '{32'hFFFF8000, 32'h00008000, 32'hFFFFFFF0, 32'h000000F0};
    xact(1'b1, 2'd2, 1'b0, 32'd8, 32'h00F08000, rd, err, lat, wcnt, wcyc);
    ref_store(2'd2, 32'd8, 32'h00F08000);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, sz[i], un[i], ad[i], 32'h0, rd, err, lat, wcnt, wcyc);
      assertions++;
      if (rd !== ex[i] || lat !== 2) begin
        failures++;
        $display("FAIL ext[%0d] got rd=%h lat=%0d want %h 2", i, rd, lat, ex[i]);
      end
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd;
    logic err;
    int lat, wcnt, wcyc;
    xact(1'b0, 2'd2, 1'b0, 32'd2, 32'h0, rd, err, lat, wcnt, wcyc);
    assertions++;
    if (err !== 1'b1 || rd !== 32'd0 || lat !== 1 || wcnt !== 0) begin
      failures++;
      $display("FAIL lw_misaligned got err=%b rd=%h lat=%0d wcnt=%0d want 1 0 1 0", err, rd, lat, wcnt);
    end
    xact(1'b1, 2'd1, 1'b0, 32'd5, 32'hCAFEBABE, rd, err, lat, wcnt, wcyc);
    assertions++;
    if (err !== 1'b1 || rd !== 32'd0 || lat !== 1 || wcnt !== 0) begin
      failures++;
      $display("FAIL sh_misaligned got err=%b rd=%h lat=%0d wcnt=%0d want 1 0 1 0", err, rd, lat, wcnt);
    end
    assertions++;
    if (mem[1] !== ref_mem[1]) begin
      failures++;
      $display("FAIL misaligned_mem got %h want %h", mem[1], ref_mem[1]);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    int cyc = 0;
    exp = ref_load(2'd2, 1'b0, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!bus.resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      assertions++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp || bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d] got valid=%b rd=%h ready=%b want 1 %h 0", i, bus.resp_valid, bus.resp_rdata, bus.req_ready, exp);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    assertions++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got valid=%b ready=%b want 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_in_write;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'd2;
    bus.req_addr = 32'd12;
    bus.req_wdata = 32'h12345678;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    assertions++;
    if (mem[3] !== ref_mem[3]) begin
      failures++;
      $display("FAIL reset_write_mem got %h want %h", mem[3], ref_mem[3]);
    end
    test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      assertions++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_write_resp[%0d] got valid=%b ready=%b want 0 1", i, bus.resp_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd, exp_rd;
    logic err, w, uns, exp_err;
    logic [1:0] sz;
    int lat, wcnt, wcyc, exp_lat, bad;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      sz = 2'($urandom);
      uns = 1'($urandom);
      a = 32'($urandom_range(0, 63));
      wd = $urandom;
      exp_err = ref_misaligned(sz, a);
      exp_rd = (exp_err || w) ? 32'd0 : ref_load(sz, uns, a);
      exp_lat = exp_err ? 1 : !w ? 2 : nbytes(sz) == 4 ? 2 : 3;
      xact(w, sz, uns, a, wd, rd, err, lat, wcnt, wcyc);
      if (w && !exp_err) ref_store(sz, a, wd);
      assertions++;
      if (rd !== exp_rd || err !== exp_err || lat !== exp_lat || wcnt !== ((w && !exp_err) ? 1 : 0)) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL rand[%0d] w=%b sz=%0d a=%0d got rd=%h err=%b lat=%0d wcnt=%0d want %h %b %0d", n, w, sz, a, rd, err, lat, wcnt, exp_rd, exp_err, exp_lat);
      end
    end
    for (int i = 0; i < 16; i++) begin
      assertions++;
      if (mem[i] !== ref_mem[i]) begin
        failures++;
        $display("FAIL rand_mem[%0d] got %h want %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_data = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_idx = 4'(i);
      pre_data = $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(posedge clk); #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_word();
    test_byte_rmw();
    test_extension();
    test_misaligned();
    test_backpressure();
    test_reset_in_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
